// File: rtl/irig_frame_ctrl.sv
// IRIG-B frame controller: sequences the frame reader, gathers decoded bits into BCD
// shadow fields, validates and commits the time, and recovers the reader after errors.
module irig_frame_ctrl #(
    parameter int unsigned MAX_ERR     = 3,
    parameter int unsigned TIMEOUT_CYC = 137500000,
    parameter int unsigned RST_CYC     = 4
) (
    input  logic       clk,
    input  logic       hrd_rst,
    input  logic       ce,
    input  logic       arm,
    input  logic       start_i,
    input  logic       terminate_i,
    input  logic       issue_i,
    input  logic [3:0] dir_i,
    input  logic       write_i,
    output logic       cal_o,
    output logic       rd_rst_o,
    output logic [6:0] sec_o,
    output logic [6:0] min_o,
    output logic [5:0] hour_o,
    output logic [9:0] day_o,
    output logic       frame_valid_o,
    output logic       locked_o,
    output logic [7:0] err_cnt_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCal     = 3'd1,
        StWait    = 3'd2,
        StCollect = 3'd3,
        StCommit  = 3'd4,
        StFail    = 3'd5,
        StResync  = 3'd6
    } state_e;

    state_e      r_state;
    logic        r_cal, r_rd_rst, r_fvalid, r_locked;
    logic [6:0]  r_sec, r_min;
    logic [5:0]  r_hour;
    logic [9:0]  r_day;
    logic [7:0]  r_err_cnt, r_consec;
    logic [31:0] r_timer, r_rst_cnt;
    logic        r_start_q, r_term_q, r_issue_q, r_bad;
    logic [3:0]  r_dir_q;
    logic [3:0]  r_shadow [9];
    logic [2:0]  r_bcnt   [9];

    logic       w_start_e, w_term_e, w_issue_e, w_timeout, w_bit_ev, w_cnt_ok, w_commit_ok;
    logic [5:0] w_hour;
    logic [9:0] w_day;

    // Dir 0..8: sec units/tens, min units/tens, hour units/tens, day units/tens/hundreds.
    function automatic logic [2:0] field_width(input int unsigned f);
        case (f)
            1, 3:    return 3'd3;
            5, 8:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign w_start_e = start_i & ~r_start_q;
    assign w_term_e  = terminate_i & ~r_term_q;
    assign w_issue_e = issue_i & ~r_issue_q;
    assign w_timeout = (r_timer == TIMEOUT_CYC);
    assign w_bit_ev  = (dir_i <= 4'd8) && (r_dir_q == 4'hF);

    always_comb begin
        w_cnt_ok = 1'b1;
        for (int unsigned f = 0; f < 9; f++) begin
            if (r_bcnt[f] != field_width(f)) w_cnt_ok = 1'b0;
        end
        w_hour = 6'(r_shadow[5][1:0]) * 6'd10 + 6'(r_shadow[4]);
        w_day  = 10'(r_shadow[8][1:0]) * 10'd100 + 10'(r_shadow[7]) * 10'd10
               + 10'(r_shadow[6]);
        w_commit_ok = !r_bad && w_cnt_ok
            && (r_shadow[0] <= 4'd9) && (r_shadow[2] <= 4'd9)
            && (r_shadow[4] <= 4'd9) && (r_shadow[6] <= 4'd9)
            && (r_shadow[1] <= 4'd5) && (r_shadow[3] <= 4'd5)
            && (w_hour <= 6'd23) && (w_day >= 10'd1) && (w_day <= 10'd366);
    end

    always_ff @(posedge clk) begin
        if (hrd_rst) begin
            r_state   <= StIdle;
            r_cal     <= 1'b0;
            r_rd_rst  <= 1'b0;
            r_fvalid  <= 1'b0;
            r_locked  <= 1'b0;
            r_sec     <= '0;
            r_min     <= '0;
            r_hour    <= '0;
            r_day     <= '0;
            r_err_cnt <= '0;
            r_consec  <= '0;
            r_timer   <= '0;
            r_rst_cnt <= '0;
            r_start_q <= 1'b0;
            r_term_q  <= 1'b0;
            r_issue_q <= 1'b0;
            r_dir_q   <= '0;
            r_bad     <= 1'b0;
            for (int unsigned f = 0; f < 9; f++) begin
                r_shadow[f] <= '0;
                r_bcnt[f]   <= '0;
            end
        end else if (ce) begin
            r_start_q <= start_i;
            r_term_q  <= terminate_i;
            r_issue_q <= issue_i;
            r_dir_q   <= dir_i;
            r_cal     <= 1'b0;
            r_fvalid  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (arm) begin
                        r_state <= StCal;
                        r_cal   <= 1'b1;
                    end
                end
                StCal: begin
                    r_timer <= '0;
                    r_state <= StWait;
                end
                StWait: begin
                    r_timer <= r_timer + 32'd1;
                    if (!arm) begin
                        r_state <= StIdle;
                    end else if (w_issue_e) begin
                        r_state <= StFail;
                    end else if (w_timeout) begin
                        r_state   <= StResync;
                        r_rd_rst  <= 1'b1;
                        r_rst_cnt <= '0;
                        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                    end else if (w_start_e) begin
                        r_state <= StCollect;
                        r_timer <= '0;
                        r_bad   <= 1'b0;
                        for (int unsigned f = 0; f < 9; f++) begin
                            r_shadow[f] <= '0;
                            r_bcnt[f]   <= '0;
                        end
                    end
                end
                StCollect: begin
                    r_timer <= r_timer + 32'd1;
                    if (w_issue_e) begin
                        r_state <= StFail;
                    end else if (w_timeout) begin
                        r_state   <= StResync;
                        r_rd_rst  <= 1'b1;
                        r_rst_cnt <= '0;
                        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                    end else if (w_term_e) begin
                        r_state <= StCommit;
                    end else if (w_bit_ev) begin
                        // LSB-first packing; a bit beyond the field width poisons the frame.
                        for (int unsigned f = 0; f < 9; f++) begin
                            if (dir_i == 4'(f)) begin
                                if (r_bcnt[f] == field_width(f)) begin
                                    r_bad <= 1'b1;
                                end else begin
                                    for (int unsigned b = 0; b < 4; b++) begin
                                        if (r_bcnt[f] == 3'(b)) r_shadow[f][b] <= write_i;
                                    end
                                    r_bcnt[f] <= r_bcnt[f] + 3'd1;
                                end
                            end
                        end
                    end
                end
                StCommit: begin
                    if (w_commit_ok) begin
                        r_sec    <= {r_shadow[1][2:0], r_shadow[0]};
                        r_min    <= {r_shadow[3][2:0], r_shadow[2]};
                        r_hour   <= {r_shadow[5][1:0], r_shadow[4]};
                        r_day    <= {r_shadow[8][1:0], r_shadow[7], r_shadow[6]};
                        r_fvalid <= 1'b1;
                        r_locked <= 1'b1;
                        r_consec <= '0;
                        if (arm) begin
                            r_state <= StCal;
                            r_cal   <= 1'b1;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else begin
                        r_state <= StFail;
                    end
                end
                StFail: begin
                    r_locked <= 1'b0;
                    r_consec <= r_consec + 8'd1;
                    if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                    // The reader restarts itself after an issue, so no cal pulse here.
                    if (r_consec + 8'd1 == 8'(MAX_ERR)) begin
                        r_state   <= StResync;
                        r_rd_rst  <= 1'b1;
                        r_rst_cnt <= '0;
                    end else begin
                        r_state <= StWait;
                    end
                end
                StResync: begin
                    r_consec <= '0;
                    r_locked <= 1'b0;
                    if (r_rst_cnt == RST_CYC - 1) begin
                        r_rd_rst <= 1'b0;
                        r_state  <= StIdle;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 32'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign cal_o         = r_cal;
    assign rd_rst_o      = r_rd_rst;
    assign sec_o         = r_sec;
    assign min_o         = r_min;
    assign hour_o        = r_hour;
    assign day_o         = r_day;
    assign frame_valid_o = r_fvalid;
    assign locked_o      = r_locked;
    assign err_cnt_o     = r_err_cnt;
    assign state_o       = r_state;

endmodule

// File: tb/tb_irig_frame_ctrl.sv
// Directed bench for irig_frame_ctrl: reset, good frame, issue, resync, timeout, bad BCD.
module tb_irig_frame_ctrl;

    logic       clk = 1'b0;
    logic       hrd_rst, ce, arm, start_i, terminate_i, issue_i, write_i;
    logic [3:0] dir_i;
    logic       cal_o, rd_rst_o, frame_valid_o, locked_o;
    logic [6:0] sec_o, min_o;
    logic [5:0] hour_o;
    logic [9:0] day_o;
    logic [7:0] err_cnt_o;
    logic [2:0] state_o;

    int n_chk  = 0;
    int n_pass = 0;
    int n;

    irig_frame_ctrl #(
        .MAX_ERR    (3),
        .TIMEOUT_CYC(1000),
        .RST_CYC    (4)
    ) dut (
        .clk          (clk),
        .hrd_rst      (hrd_rst),
        .ce           (ce),
        .arm          (arm),
        .start_i      (start_i),
        .terminate_i  (terminate_i),
        .issue_i      (issue_i),
        .dir_i        (dir_i),
        .write_i      (write_i),
        .cal_o        (cal_o),
        .rd_rst_o     (rd_rst_o),
        .sec_o        (sec_o),
        .min_o        (min_o),
        .hour_o       (hour_o),
        .day_o        (day_o),
        .frame_valid_o(frame_valid_o),
        .locked_o     (locked_o),
        .err_cnt_o    (err_cnt_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic [3:0] d, input logic v);
        dir_i   = d;
        write_i = v;
        tick();
        dir_i = 4'hF;
        tick();
    endtask

    task automatic send_field(input logic [3:0] d, input logic [3:0] v, input int w);
        for (int b = 0; b < w; b++) send_bit(d, v[b]);
    endtask

    task automatic send_frame(input logic [6:0] s, input logic [6:0] m, input logic [5:0] h,
                              input logic [9:0] dy);
        send_field(4'd0, s[3:0], 4);
        send_field(4'd1, {1'b0, s[6:4]}, 3);
        send_field(4'd2, m[3:0], 4);
        send_field(4'd3, {1'b0, m[6:4]}, 3);
        send_field(4'd4, h[3:0], 4);
        send_field(4'd5, {2'b0, h[5:4]}, 2);
        send_field(4'd6, dy[3:0], 4);
        send_field(4'd7, dy[7:4], 4);
        send_field(4'd8, {2'b0, dy[9:8]}, 2);
    endtask

    task automatic start_edge();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        hrd_rst = 1'b1; ce = 1'b1; arm = 1'b1; start_i = 1'b0; terminate_i = 1'b0;
        issue_i = 1'b0; dir_i = 4'hF; write_i = 1'b0;

        // Reset
        tick(); tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_cal", 32'(cal_o), 32'd0);
        chk("rst_sec", 32'(sec_o), 32'd0);
        chk("rst_day", 32'(day_o), 32'd0);
        chk("rst_err", 32'(err_cnt_o), 32'd0);
        chk("rst_rdrst", 32'(rd_rst_o), 32'd0);
        hrd_rst = 1'b0;
        tick();
        chk("cal_state", 32'(state_o), 32'd1);
        chk("cal_pulse", 32'(cal_o), 32'd1);
        tick();
        chk("wait_state", 32'(state_o), 32'd2);
        chk("cal_low", 32'(cal_o), 32'd0);

        // Good frame 23:59:58 day 365
        start_edge();
        chk("collect_state", 32'(state_o), 32'd3);
        send_frame(7'h58, 7'h59, 6'h23, 10'h365);
        terminate_i = 1'b1;
        tick();
        chk("commit_state", 32'(state_o), 32'd4);
        chk("fv_early", 32'(frame_valid_o), 32'd0);
        terminate_i = 1'b0;
        tick();
        chk("fv_pulse", 32'(frame_valid_o), 32'd1);
        chk("good_sec", 32'(sec_o), 32'h58);
        chk("good_min", 32'(min_o), 32'h59);
        chk("good_hour", 32'(hour_o), 32'h23);
        chk("good_day", 32'(day_o), 32'h365);
        chk("good_locked", 32'(locked_o), 32'd1);
        chk("good_cal", 32'(cal_o), 32'd1);
        chk("good_next", 32'(state_o), 32'd1);
        tick();
        chk("fv_single", 32'(frame_valid_o), 32'd0);
        chk("good_wait", 32'(state_o), 32'd2);

        // Issue after 10 bits
        start_edge();
        send_field(4'd0, 4'h1, 4);
        send_field(4'd1, 4'h2, 3);
        send_field(4'd2, 4'h3, 3);
        issue_i = 1'b1;
        tick();
        chk("issue_fail", 32'(state_o), 32'd5);
        issue_i = 1'b0;
        tick();
        chk("issue_wait", 32'(state_o), 32'd2);
        chk("issue_err", 32'(err_cnt_o), 32'd1);
        chk("issue_unlock", 32'(locked_o), 32'd0);
        chk("issue_keep_sec", 32'(sec_o), 32'h58);
        chk("issue_keep_day", 32'(day_o), 32'h365);

        // Two more consecutive issues -> resync
        start_edge();
        issue_i = 1'b1;
        tick();
        issue_i = 1'b0;
        tick();
        chk("issue2_err", 32'(err_cnt_o), 32'd2);
        chk("issue2_wait", 32'(state_o), 32'd2);
        start_edge();
        issue_i = 1'b1;
        tick();
        issue_i = 1'b0;
        tick();
        chk("resync_state", 32'(state_o), 32'd6);
        chk("resync_err", 32'(err_cnt_o), 32'd3);
        n = 0;
        while (rd_rst_o === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("rdrst_len", 32'(n), 32'd4);
        chk("resync_idle", 32'(state_o), 32'd0);
        tick();
        chk("recal", 32'(cal_o), 32'd1);
        tick();

        // Watchdog timeout in COLLECT
        start_edge();
        repeat (1000) tick();
        chk("to_before", 32'(state_o), 32'd3);
        tick();
        chk("to_resync", 32'(state_o), 32'd6);
        chk("to_err", 32'(err_cnt_o), 32'd4);
        chk("to_rdrst", 32'(rd_rst_o), 32'd1);
        n = 0;
        while (rd_rst_o === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("to_rdrst_len", 32'(n), 32'd4);
        tick(); tick();
        chk("to_wait", 32'(state_o), 32'd2);

        // Bad BCD: sec units 0xA
        start_edge();
        send_frame(7'h5A, 7'h59, 6'h23, 10'h365);
        terminate_i = 1'b1;
        tick();
        terminate_i = 1'b0;
        tick();
        chk("bcd_fail", 32'(state_o), 32'd5);
        chk("bcd_nofv", 32'(frame_valid_o), 32'd0);
        tick();
        chk("bcd_err", 32'(err_cnt_o), 32'd5);
        chk("bcd_keep_sec", 32'(sec_o), 32'h58);

        // Fifth bit on dir 0
        start_edge();
        send_frame(7'h12, 7'h34, 6'h05, 10'h123);
        send_bit(4'd0, 1'b1);
        terminate_i = 1'b1;
        tick();
        terminate_i = 1'b0;
        tick();
        chk("ovf_fail", 32'(state_o), 32'd5);
        chk("ovf_nofv", 32'(frame_valid_o), 32'd0);
        tick();
        chk("ovf_err", 32'(err_cnt_o), 32'd6);
        chk("ovf_keep_min", 32'(min_o), 32'h59);

        // Reset mid-COLLECT, then clock-enable hold
        start_edge();
        send_field(4'd0, 4'h7, 4);
        hrd_rst = 1'b1;
        tick();
        chk("midrst_state", 32'(state_o), 32'd0);
        chk("midrst_err", 32'(err_cnt_o), 32'd0);
        chk("midrst_sec", 32'(sec_o), 32'd0);
        hrd_rst = 1'b0;
        ce = 1'b0;
        tick(); tick();
        chk("ce_hold", 32'(state_o), 32'd0);
        ce = 1'b1;
        tick();
        chk("ce_run", 32'(state_o), 32'd1);
        tick(); tick();
        chk("midrst_noerr", 32'(err_cnt_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
